mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 The block SHALL have parameter ACK_TIMEOUT, default 15, meaning the number of ACCESS cycles without i_memAck before the request is abandoned.
REQ-002 i_clk  in  1  single clock; all state changes on its rising edge.
REQ-003 i_rstn  in  1  reset, asynchronous, active-low.
REQ-004 i_valid  in  1  execute stage presents an op this cycle.
REQ-005 i_aluResult  in  16  ALU o_result; this is the memory address for load/store, or the writeback value otherwise.
REQ-006 i_storeData  in  16  register value to store.
REQ-007 i_isLoad  in  1  op is a load.
REQ-008 i_isStore  in  1  op is a store.
REQ-009 i_dstReg  in  3  destination register index.
REQ-010 o_stall  out  1  upstream SHALL hold its op; the op is not consumed.
REQ-011 o_memAddr  out  16  memory word address.
REQ-012 o_memWrData  out  16  store data.
REQ-013 o_memRen  out  1  read request, level, held until ack or timeout.
REQ-014 o_memWen  out  1  write request, level, held until ack or timeout.
REQ-015 i_memRdData  in  16  read data, valid in the i_memAck cycle.
REQ-016 i_memAck  in  1  memory completes the current request this cycle.
REQ-017 o_wbValid  out  1  one-cycle pulse: o_wbData/o_wbReg are to be written.
REQ-018 o_wbData  out  16  writeback value.
REQ-019 o_wbReg  out  3  writeback register index.
REQ-020 o_busErr  out  1  sticky bus-timeout flag.

Function
REQ-021 The FSM SHALL have two states, IDLE and ACCESS; o_stall SHALL equal (state==ACCESS), combinationally.
REQ-022 In IDLE with i_valid=1 and i_isLoad=i_isStore=0: next cycle o_wbValid=1, o_wbData=i_aluResult, o_wbReg=i_dstReg; the FSM stays in IDLE (1-cycle latency, 1 op/cycle).
REQ-023 In IDLE with i_valid=1 and i_isLoad|i_isStore: latch address=i_aluResult, data=i_storeData, reg=i_dstReg and type; go to ACCESS; o_wbValid=0 next cycle.
REQ-024 When i_isLoad and i_isStore are both 1, the op SHALL be treated as a load.
REQ-025 In ACCESS: o_memAddr/o_memWrData SHALL present the latched values; o_memRen=1 for a load or o_memWen=1 for a store, never both; all are registered outputs, stable for the whole ACCESS period.
REQ-026 In ACCESS, i_valid and the other upstream inputs SHALL be ignored.
REQ-027 In ACCESS with i_memAck=1 for a load: next cycle o_wbValid=1, o_wbData=i_memRdData (sampled in the ack cycle), o_wbReg=latched reg; request deasserted; go to IDLE.
REQ-028 In ACCESS with i_memAck=1 for a store: request deasserted; go to IDLE; o_wbValid stays 0.
REQ-029 A 4-bit-minimum wait counter SHALL clear on entry to ACCESS and increment each ACCESS cycle without ack.
REQ-030 When the counter reaches ACK_TIMEOUT without an ack: set o_busErr=1, deassert the request, go to IDLE, o_wbValid=0.
REQ-031 An ack in the same cycle the timeout is reached SHALL take priority: normal completion, no error.
REQ-032 o_busErr SHALL clear only on reset.
REQ-033 i_memAck in IDLE SHALL be ignored.
REQ-034 The minimum memory op SHALL occupy 2 cycles (capture, then ACCESS with immediate ack); the op after it SHALL be accepted in the cycle after the ack.
REQ-035 Outside the cycles specified in REQ-022 and REQ-027, o_wbValid SHALL be 0; o_wbData/o_wbReg SHALL hold their last values.

Reset
REQ-036 On i_rstn=0, immediately and asynchronously: state=IDLE, counter=0, and all outputs 0 (o_stall, o_memRen, o_memWen, o_memAddr, o_memWrData, o_wbValid, o_wbData, o_wbReg, o_busErr).
REQ-037 A reset during ACCESS SHALL abandon the request with no writeback; a late ack after reset release SHALL be ignored per REQ-033.

Verification
REQ-038 Non-memory op: i_aluResult=0x1234, i_dstReg=5 -> next cycle o_wbValid=1, o_wbData=0x1234, o_wbReg=5, o_stall=0.
REQ-039 Load: addr 0x00A0, ack after 3 wait cycles with rdData 0xBEEF -> o_memRen=1 and o_stall=1 for 4 cycles; then o_wbValid=1, o_wbData=0xBEEF; the next op is accepted.
REQ-040 Store: addr 0x0010, data 0x5A5A, ack immediately -> o_memWen=1 for 1 cycle with o_memAddr=0x0010 and o_memWrData=0x5A5A; no o_wbValid pulse.
REQ-041 Timeout: load with no ack -> after 15 ACCESS cycles o_memRen=0, o_busErr=1 (sticky), no writeback; ack at cycle 15 -> completes normally with o_busErr=0.
REQ-042 Reset mid-ACCESS (store, cycle 2) -> all outputs 0 immediately; an ack pulse after reset release produces no activity.
REQ-043 Back-to-back ops: non-memory, load, non-memory -> the third op is held by o_stall and its writeback occurs after the load's writeback, in order.

Source files
------------

// File: rtl/mem_access.sv
// Memory-access stage: non-memory ops pass straight to writeback; loads and stores
// are captured and held on a level request until the memory acks or the wait times out.
module mem_access #(
    parameter int ACK_TIMEOUT = 15
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_valid,
    input  logic [15:0] i_aluResult,
    input  logic [15:0] i_storeData,
    input  logic        i_isLoad,
    input  logic        i_isStore,
    input  logic [2:0]  i_dstReg,
    output logic        o_stall,
    output logic [15:0] o_memAddr,
    output logic [15:0] o_memWrData,
    output logic        o_memRen,
    output logic        o_memWen,
    input  logic [15:0] i_memRdData,
    input  logic        i_memAck,
    output logic        o_wbValid,
    output logic [15:0] o_wbData,
    output logic [2:0]  o_wbReg,
    output logic        o_busErr,
    output logic        o_state
);

    // Handshake: upstream presents an op with i_valid; the op is consumed on any
    // rising edge where o_stall is low, and held by upstream while o_stall is high.
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACCESS = 1'b1;

    localparam int CW = ($clog2(ACK_TIMEOUT + 1) > 4) ? $clog2(ACK_TIMEOUT + 1) : 4;
    localparam logic [CW-1:0] WAIT_LAST = CW'(ACK_TIMEOUT - 1);

    logic [0:0]    state;
    logic [CW-1:0] wait_cnt;
    logic [2:0]    op_reg;

    assign o_stall = (state == ACCESS);
    assign o_state = state[0];

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            op_reg      <= '0;
            o_memAddr   <= '0;
            o_memWrData <= '0;
            o_memRen    <= 1'b0;
            o_memWen    <= 1'b0;
            o_wbValid   <= 1'b0;
            o_wbData    <= '0;
            o_wbReg     <= '0;
            o_busErr    <= 1'b0;
        end else begin
            o_wbValid <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_valid && (i_isLoad || i_isStore)) begin
                        // A load/store collision resolves to a load.
                        state       <= ACCESS;
                        wait_cnt    <= '0;
                        op_reg      <= i_dstReg;
                        o_memAddr   <= i_aluResult;
                        o_memWrData <= i_storeData;
                        o_memRen    <= i_isLoad;
                        o_memWen    <= !i_isLoad;
                    end else if (i_valid) begin
                        o_wbValid <= 1'b1;
                        o_wbData  <= i_aluResult;
                        o_wbReg   <= i_dstReg;
                    end
                end
                ACCESS: begin
                    if (i_memAck) begin
                        // Ack wins over a timeout reached in the same cycle.
                        state    <= IDLE;
                        o_memRen <= 1'b0;
                        o_memWen <= 1'b0;
                        if (o_memRen) begin
                            o_wbValid <= 1'b1;
                            o_wbData  <= i_memRdData;
                            o_wbReg   <= op_reg;
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        state    <= IDLE;
                        o_memRen <= 1'b0;
                        o_memWen <= 1'b0;
                        o_busErr <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: transaction-level model checked every cycle,
// writeback scoreboard, and hand-computed expectations for each scenario.
module tb_mem_access;

    localparam int TO = 15;

    logic        clk;
    logic        rstn;
    logic        valid;
    logic [15:0] alu;
    logic [15:0] sd;
    logic        is_load;
    logic        is_store;
    logic [2:0]  dst;
    logic        stall;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ren;
    logic        mem_wen;
    logic [15:0] mem_rd;
    logic        mem_ack;
    logic        wb_valid;
    logic [15:0] wb_data;
    logic [2:0]  wb_reg;
    logic        bus_err;
    logic        dbg_state;

    int errors = 0;
    int checks = 0;

    logic [18:0] exp_q[$];

    mem_access #(.ACK_TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rstn(rstn), .i_valid(valid), .i_aluResult(alu),
        .i_storeData(sd), .i_isLoad(is_load), .i_isStore(is_store), .i_dstReg(dst),
        .o_stall(stall), .o_memAddr(mem_addr), .o_memWrData(mem_wdata),
        .o_memRen(mem_ren), .o_memWen(mem_wen), .i_memRdData(mem_rd),
        .i_memAck(mem_ack), .o_wbValid(wb_valid), .o_wbData(wb_data),
        .o_wbReg(wb_reg), .o_busErr(bus_err), .o_state(dbg_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // model: pending memory transaction plus the writeback it owes
    logic        m_busy, m_load, m_err, m_wb_valid;
    logic [15:0] m_addr, m_wdata, m_wb_data;
    logic [2:0]  m_reg, m_wb_reg;
    int          m_waited;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_busy <= 1'b0; m_load <= 1'b0; m_err <= 1'b0; m_wb_valid <= 1'b0;
            m_addr <= '0; m_wdata <= '0; m_wb_data <= '0; m_reg <= '0; m_wb_reg <= '0;
            m_waited <= 0;
        end else begin
            m_wb_valid <= 1'b0;
            if (!m_busy) begin
                if (valid && (is_load || is_store)) begin
                    m_busy <= 1'b1; m_load <= is_load; m_addr <= alu;
                    m_wdata <= sd; m_reg <= dst; m_waited <= 0;
                end else if (valid) begin
                    m_wb_valid <= 1'b1; m_wb_data <= alu; m_wb_reg <= dst;
                    exp_q.push_back({dst, alu});
                end
            end else if (mem_ack) begin
                m_busy <= 1'b0;
                if (m_load) begin
                    m_wb_valid <= 1'b1; m_wb_data <= mem_rd; m_wb_reg <= m_reg;
                    exp_q.push_back({m_reg, mem_rd});
                end
            end else if (m_waited + 1 == TO) begin
                m_busy <= 1'b0;
                m_err <= 1'b1;
            end else begin
                m_waited <= m_waited + 1;
            end
        end
    end

    // compare process
    always @(negedge clk) begin
        logic [18:0] got;
        chk("stall", stall, m_busy);
        chk("state", dbg_state, m_busy);
        chk("mem_ren", mem_ren, m_busy && m_load);
        chk("mem_wen", mem_wen, m_busy && !m_load);
        chk("wb_valid", wb_valid, m_wb_valid);
        chk("wb_data", wb_data, m_wb_data);
        chk("wb_reg", wb_reg, m_wb_reg);
        chk("bus_err", bus_err, m_err);
        if (m_busy) begin
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_wdata", mem_wdata, m_wdata);
        end
        if (wb_valid === 1'b1) begin
            got = {wb_reg, wb_data};
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_wb", got, 19'h0);
            end else begin
                chk("sb_wb", got, exp_q.pop_front());
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_op(input logic v, input logic [15:0] a, input logic [15:0] s,
                          input logic l, input logic st, input logic [2:0] d);
        valid = v; alu = a; sd = s; is_load = l; is_store = st; dst = d;
    endtask

    int n;

    initial begin
        rstn = 1'b0; mem_ack = 1'b0; mem_rd = '0;
        set_op(0, 16'h0, 16'h0, 0, 0, 3'd0);
        tick(); tick();
        chk("rst_stall", stall, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_bus_err", bus_err, 0);
        chk("rst_mem_addr", mem_addr, 0);
        rstn = 1'b1;
        tick();

        // non-memory op
        set_op(1, 16'h1234, 16'h0, 0, 0, 3'd5);
        tick();
        chk("alu_wb_valid", wb_valid, 1);
        chk("alu_wb_data", wb_data, 16'h1234);
        chk("alu_wb_reg", wb_reg, 5);
        chk("alu_stall", stall, 0);
        set_op(0, 16'h0, 16'h0, 0, 0, 3'd0);
        tick();
        chk("alu_wb_valid_drop", wb_valid, 0);
        chk("alu_wb_data_hold", wb_data, 16'h1234);

        // load with 3 wait cycles; upstream junk during ACCESS must be ignored
        set_op(1, 16'h00A0, 16'h0, 1, 0, 3'd2);
        tick();
        chk("ld_addr", mem_addr, 16'h00A0);
        n = 0;
        for (int k = 0; k < 4; k++) begin
            if (mem_ren && stall) n++;
            set_op(1, 16'hFFFF, 16'hEEEE, 0, 1, 3'd7);
            if (k == 3) begin mem_ack = 1'b1; mem_rd = 16'hBEEF; end
            tick();
        end
        mem_ack = 1'b0;
        chk("ld_ren_cycles", n, 4);
        chk("ld_wb_valid", wb_valid, 1);
        chk("ld_wb_data", wb_data, 16'hBEEF);
        chk("ld_wb_reg", wb_reg, 2);
        chk("ld_ren_off", mem_ren, 0);
        set_op(1, 16'h0077, 16'h0, 0, 0, 3'd1);
        tick();
        chk("ld_next_accept", wb_data, 16'h0077);

        // store with immediate ack
        set_op(1, 16'h0010, 16'h5A5A, 0, 1, 3'd3);
        tick();
        chk("st_wen", mem_wen, 1);
        chk("st_ren", mem_ren, 0);
        chk("st_addr", mem_addr, 16'h0010);
        chk("st_wdata", mem_wdata, 16'h5A5A);
        set_op(0, 16'h0, 16'h0, 0, 0, 3'd0);
        mem_ack = 1'b1;
        tick();
        chk("st_wen_off", mem_wen, 0);
        chk("st_no_wb", wb_valid, 0);
        tick();
        chk("idle_ack_ignored", stall, 0);
        chk("idle_ack_no_wb", wb_valid, 0);
        mem_ack = 1'b0;

        // load+store together acts as a load
        set_op(1, 16'h0040, 16'h1111, 1, 1, 3'd4);
        tick();
        chk("both_ren", mem_ren, 1);
        chk("both_wen", mem_wen, 0);
        set_op(0, 16'h0, 16'h0, 0, 0, 3'd0);
        mem_ack = 1'b1; mem_rd = 16'h2222;
        tick();
        mem_ack = 1'b0;
        chk("both_wb_data", wb_data, 16'h2222);
        chk("both_wb_reg", wb_reg, 4);

        // ack in the 15th ACCESS cycle completes normally
        set_op(1, 16'h0050, 16'h0, 1, 0, 3'd6);
        tick();
        set_op(0, 16'h0, 16'h0, 0, 0, 3'd0);
        repeat (TO - 1) tick();
        chk("late_ack_ren", mem_ren, 1);
        mem_ack = 1'b1; mem_rd = 16'hCAFE;
        tick();
        mem_ack = 1'b0;
        chk("late_ack_wb", wb_data, 16'hCAFE);
        chk("late_ack_no_err", bus_err, 0);

        // timeout
        set_op(1, 16'h0060, 16'h0, 1, 0, 3'd7);
        tick();
        set_op(0, 16'h0, 16'h0, 0, 0, 3'd0);
        n = 0;
        while (stall && n < 20) begin
            n++;
            tick();
        end
        chk("to_cycles", n, TO);
        chk("to_ren_off", mem_ren, 0);
        chk("to_bus_err", bus_err, 1);
        chk("to_no_wb", wb_valid, 0);
        chk("to_wb_hold", wb_data, 16'hCAFE);

        // back-to-back: non-memory, load, non-memory held by stall
        set_op(1, 16'h0101, 16'h0, 0, 0, 3'd1);
        tick();
        chk("b2b_first", wb_data, 16'h0101);
        set_op(1, 16'h0A0A, 16'h0, 1, 0, 3'd2);
        tick();
        chk("b2b_stall", stall, 1);
        set_op(1, 16'h0303, 16'h0, 0, 0, 3'd3);
        mem_ack = 1'b1; mem_rd = 16'h0202;
        tick();
        mem_ack = 1'b0;
        chk("b2b_load_wb", {wb_reg, wb_data}, {3'd2, 16'h0202});
        tick();
        chk("b2b_third_wb", {wb_reg, wb_data}, {3'd3, 16'h0303});
        chk("b2b_err_sticky", bus_err, 1);
        set_op(0, 16'h0, 16'h0, 0, 0, 3'd0);
        tick();

        // reset in the second ACCESS cycle of a store
        set_op(1, 16'h0030, 16'h7777, 0, 1, 3'd0);
        tick();
        set_op(0, 16'h0, 16'h0, 0, 0, 3'd0);
        tick();
        rstn = 1'b0;
        #1;
        chk("rst_mid_stall", stall, 0);
        chk("rst_mid_wen", mem_wen, 0);
        chk("rst_mid_addr", mem_addr, 0);
        chk("rst_mid_wdata", mem_wdata, 0);
        chk("rst_mid_wb_data", wb_data, 0);
        chk("rst_mid_wb_reg", wb_reg, 0);
        chk("rst_mid_err", bus_err, 0);
        tick();
        rstn = 1'b1;
        tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("post_rst_ack_stall", stall, 0);
        chk("post_rst_ack_wen", mem_wen, 0);
        chk("post_rst_ack_wb", wb_valid, 0);
        tick();

        chk("sb_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
